alu_sequencer: RTL

Command-side initiator for the 8-bit `alu`. It buffers operation requests in a small FIFO and issues them one at a time on the ALU's `select`/`A`/`B` inputs. It holds the operands stable until the ALU completes its `done` handshake, then returns the 16-bit result, the ALU flags and a timeout flag on a valid/ready response port. It sits between a bus-side controller and the `alu` top.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_cmd_fifo.sv | 51 +++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU command sequencer.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLAG_OVF   = 4;
  localparam int FLAG_NEG   = 3;
  localparam int FLAG_ZERO  = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_DIV0  = 0;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_DONE    = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_RESP         = 2'd3;

  typedef struct packed {
    logic [1:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; read data is the head entry, visible combinationally.
// Full/empty are told apart by one extra pointer bit above the index.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  cmd_t wdata,
  input  logic pop,
  output cmd_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands and issues them one at a time, holding operands through the ALU done handshake.
// Result/flags (or a timeout marker) are returned on a valid/ready response port.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  output logic [1:0]  alu_select,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  input  logic [4:0]  alu_flags,
  input  logic        alu_done,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_op,
  output logic [15:0] rsp_result,
  output logic [4:0]  rsp_flags,
  output logic        rsp_timeout,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT);

  logic        full, empty, push, pop;
  cmd_t        head;

  logic [1:0]  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  sel_q, sel_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [1:0]  rsp_op_q, rsp_op_d;
  logic [15:0] rsp_result_q, rsp_result_d;
  logic [4:0]  rsp_flags_q, rsp_flags_d;
  logic        rsp_timeout_q, rsp_timeout_d;

  assign push = cmd_valid && !full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({cmd_op, cmd_a, cmd_b}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sel_d         = sel_q;
    a_d           = a_q;
    b_d           = b_q;
    rsp_op_d      = rsp_op_q;
    rsp_result_d  = rsp_result_q;
    rsp_flags_d   = rsp_flags_q;
    rsp_timeout_d = rsp_timeout_q;
    pop           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          sel_d   = head.op;
          a_d     = head.a;
          b_d     = head.b;
          cnt_d   = '0;
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (alu_done) begin
          rsp_op_d      = sel_q;
          rsp_result_d  = alu_result;
          rsp_flags_d   = alu_flags;
          rsp_timeout_d = 1'b0;
          state_d       = ST_WAIT_RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_op_d      = sel_q;
          rsp_result_d  = '0;
          rsp_flags_d   = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      // Operands stay put until the ALU drops done, closing its handshake.
      ST_WAIT_RELEASE: begin
        if (!alu_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sel_q         <= '0;
      a_q           <= '0;
      b_q           <= '0;
      rsp_op_q      <= '0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sel_q         <= sel_d;
      a_q           <= a_d;
      b_q           <= b_d;
      rsp_op_q      <= rsp_op_d;
      rsp_result_q  <= rsp_result_d;
      rsp_flags_q   <= rsp_flags_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = !full;
  assign alu_select  = sel_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_valid   = (state_q == ST_RESP);
  assign rsp_op      = rsp_op_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
